dll_tx_tlp_framer: RTL and testbench
====================================

DLL_TX_TLP_FRAMER -- requirements
Module: dll_tx_tlp_framer

Interface
REQ-001 SHALL provide parameter TLP_W, default 1152, width of the TLP payload in bits (multiple of 32, minimum 64).
REQ-002 SHALL provide parameter MAX_OUTSTANDING, default 2047, maximum number of unacknowledged TLPs (1..2047).
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port rst_n  input  1  reset: synchronous, active-low; the clock is clk.
REQ-005 SHALL provide port dlc_state_i  input  2  DLCMSM state: 2'b00 DL_INACTIVE, 2'b11 DL_ACTIVE, other values not active.
REQ-006 SHALL provide port tlp_i  input  TLP_W  TLP from the transaction layer.
REQ-007 SHALL provide port tlp_valid_i  input  1  tlp_i is valid.
REQ-008 SHALL provide port tlp_ready_o  output  1  block accepts tlp_i this cycle.
REQ-009 SHALL provide port dll_tlp_o  output  TLP_W+44  framed TLP: [TLP_W+43:TLP_W+32] sequence number, [TLP_W+31:32] TLP, [31:0] LCRC.
REQ-010 SHALL provide port dll_tlp_valid_o  output  1  dll_tlp_o is valid.
REQ-011 SHALL provide port dll_tlp_ready_i  input  1  downstream accepts dll_tlp_o.
REQ-012 SHALL provide port ack_valid_i  input  1  Ack DLLP received.
REQ-013 SHALL provide port ack_seq_i  input  12  AckNak_Seq_Num carried by the Ack.
REQ-014 SHALL provide port next_seq_o  output  12  NEXT_TRANSMIT_SEQ.
REQ-015 SHALL provide port acked_seq_o  output  12  ACKD_SEQ.

Function
REQ-016 SHALL implement an FSM with states IDLE, CALC and SEND.
REQ-017 SHALL drive tlp_ready_o=1 only in IDLE, only when dlc_state_i==2'b11, and only when outstanding < MAX_OUTSTANDING.
REQ-018 SHALL compute outstanding as (next_seq - acked_seq - 1) mod 4096.
REQ-019 SHALL, on tlp_valid_i && tlp_ready_o in IDLE, capture tlp_i and move to CALC.
REQ-020 SHALL, in CALC, register the LCRC over {4'b0000, next_seq, tlp} and move to SEND.
REQ-021 SHALL, in SEND, assert dll_tlp_valid_o and hold dll_tlp_o stable until dll_tlp_ready_i is 1.
REQ-022 SHALL, on the SEND handshake, increment next_seq modulo 4096 (4095 wraps to 0) and return to IDLE.
REQ-023 SHALL have a latency from the accept edge to dll_tlp_valid_o=1 of exactly 2 cycles, with no back-to-back accepts; the minimum spacing between accepts is 3 cycles.
REQ-024 SHALL accept ack_valid_i only when (next_seq-1-ack_seq_i) mod 4096 < (next_seq-1-acked_seq) mod 4096; it then sets acked_seq=ack_seq_i, otherwise the Ack is ignored.
REQ-025 SHALL, when an Ack and a SEND handshake occur in the same cycle, apply both, evaluating the Ack against pre-increment values.
REQ-026 SHALL, if dlc_state_i leaves 2'b11 during CALC or SEND, discard the held TLP, deassert dll_tlp_valid_o next cycle, return to IDLE and not increment next_seq.
REQ-027 SHALL, while dlc_state_i==2'b00, force next_seq=0 and acked_seq=4095; any Ack received in that state is ignored.
REQ-028 SHALL have dll_tlp_valid_o, tlp_ready_o and the FSM state as registered outputs or derived only from registered state and dlc_state_i; there is no combinational path from tlp_valid_i.

Reset
REQ-029 SHALL, on rst_n=0 at a clk edge, set state=IDLE, next_seq=0, acked_seq=4095, dll_tlp_o=0, dll_tlp_valid_o=0 and the captured TLP/LCRC=0.
REQ-030 SHALL give reset priority over all other events, including reset mid-SEND, after which no handshake is completed.

Configuration
REQ-031 SHALL, with DLL_TX_LCRC_EN defined, compute the LCRC as CRC-32 with polynomial 04C11DB7, initial value FFFFFFFF, MSB-first over the 16+TLP_W bits, with the result inverted.
REQ-032 SHALL, without DLL_TX_LCRC_EN, use the constant DEADBEEF as the LCRC, omit the CRC logic entirely and leave the FSM timing unchanged.

Verification
REQ-033 SHALL cover: macro off, DL_ACTIVE, a single TLP of all 0xA5 with ready high -> valid 2 cycles after accept, seq=0, LCRC=DEADBEEF, next_seq_o=1.
REQ-034 SHALL cover: dll_tlp_ready_i held low for 5 cycles in SEND -> dll_tlp_o stable, valid held, tlp_ready_o=0 throughout.
REQ-035 SHALL cover: MAX_OUTSTANDING=4 with no Acks and 6 TLPs offered -> 4 sent (seq 0..3) and tlp_ready_o=0; then Ack seq=1 -> acked_seq_o=1 and 2 more sent.
REQ-036 SHALL cover: next_seq forced to 4095 via sends, one more TLP sent -> seq 4095 emitted and next_seq_o wraps to 0; then a stale Ack seq=4000 is ignored.
REQ-037 SHALL cover: dlc_state_i driven to 2'b01 during SEND -> valid drops the next cycle and next_seq unchanged; then 2'b00 -> next_seq_o=0 and acked_seq_o=4095.
REQ-038 SHALL cover: macro on, seq=0, compared against a reference CRC-32 model over 100 random TLPs -> all LCRCs match.

Source files
------------

// File: rtl/dll_tx_tlp_framer.sv
// Data link layer transmit framer: takes a TLP, tags it with NEXT_TRANSMIT_SEQ,
// appends an LCRC and hands the frame downstream. Tracks ACKD_SEQ from incoming Acks
// to limit the number of unacknowledged TLPs in flight.
// Optional feature macro: DLL_TX_LCRC_EN selects a real CRC-32 LCRC; when it is not
// defined the LCRC field is the constant DEADBEEF.
module dll_tx_tlp_framer #(
    parameter int unsigned TLP_W           = 1152,
    parameter int unsigned MAX_OUTSTANDING = 2047
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         dlc_state_i,
    input  logic [TLP_W-1:0]   tlp_i,
    input  logic               tlp_valid_i,
    output logic               tlp_ready_o,
    output logic [TLP_W+43:0]  dll_tlp_o,
    output logic               dll_tlp_valid_o,
    input  logic               dll_tlp_ready_i,
    input  logic               ack_valid_i,
    input  logic [11:0]        ack_seq_i,
    output logic [11:0]        next_seq_o,
    output logic [11:0]        acked_seq_o
);

    localparam logic [11:0] MaxOut = 12'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StCalc, StSend} state_e;

    state_e           state_q, state_d;
    logic [11:0]      next_seq_q, next_seq_d;
    logic [11:0]      acked_seq_q, acked_seq_d;
    logic [TLP_W-1:0] tlp_q, tlp_d;
    logic [31:0]      lcrc_q, lcrc_d;

    logic             dl_active;
    logic             dl_inactive;
    logic [11:0]      outstanding;
    logic [11:0]      ack_dist;
    logic             ack_ok;

`ifdef DLL_TX_LCRC_EN
    // Bit-serial CRC-32, MSB first, seeded with all ones and inverted at the end.
    function automatic logic [31:0] lcrc_calc(input logic [TLP_W+15:0] data);
        logic [TLP_W+15:0] d;
        logic [31:0]       crc;
        logic              fb;
        d   = data;
        crc = 32'hFFFF_FFFF;
        for (int unsigned i = 0; i < TLP_W + 16; i++) begin
            fb  = crc[31] ^ d[TLP_W+15];
            d   = d << 1;
            crc = {crc[30:0], 1'b0};
            if (fb) begin
                crc = crc ^ 32'h04C1_1DB7;
            end
        end
        return ~crc;
    endfunction
`endif

    // Link status, replay-window occupancy and Ack acceptance (all modulo 4096).
    always_comb begin
        dl_active   = (dlc_state_i == 2'b11);
        dl_inactive = (dlc_state_i == 2'b00);
        outstanding = next_seq_q - acked_seq_q - 12'd1;
        ack_dist    = next_seq_q - 12'd1 - ack_seq_i;
        // An Ack is only useful if it moves ACKD_SEQ forward within the sent window.
        ack_ok      = ack_valid_i && !dl_inactive && (ack_dist < outstanding);
    end

    // Registered-state-only outputs; no path from tlp_valid_i.
    always_comb begin
        tlp_ready_o     = (state_q == StIdle) && dl_active && (outstanding < MaxOut);
        dll_tlp_valid_o = (state_q == StSend);
        dll_tlp_o       = {next_seq_q, tlp_q, lcrc_q};
        next_seq_o      = next_seq_q;
        acked_seq_o     = acked_seq_q;
    end

    // FSM next state plus sequence number bookkeeping.
    always_comb begin
        state_d     = state_q;
        next_seq_d  = next_seq_q;
        acked_seq_d = acked_seq_q;
        tlp_d       = tlp_q;
        lcrc_d      = lcrc_q;

        unique case (state_q)
            StIdle: begin
                if (tlp_valid_i && tlp_ready_o) begin
                    tlp_d   = tlp_i;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!dl_active) begin
                    state_d = StIdle;
                end else begin
`ifdef DLL_TX_LCRC_EN
                    lcrc_d = lcrc_calc({4'b0000, next_seq_q, tlp_q});
`else
                    lcrc_d = 32'hDEAD_BEEF;
`endif
                    state_d = StSend;
                end
            end
            StSend: begin
                // Link loss drops the frame without consuming a sequence number.
                if (!dl_active) begin
                    state_d = StIdle;
                end else if (dll_tlp_ready_i) begin
                    next_seq_d = next_seq_q + 12'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Ack is judged against pre-increment next_seq_q.
        if (ack_ok) begin
            acked_seq_d = ack_seq_i;
        end

        if (dl_inactive) begin
            next_seq_d  = 12'd0;
            acked_seq_d = 12'hFFF;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            next_seq_q  <= 12'd0;
            acked_seq_q <= 12'hFFF;
            tlp_q       <= '0;
            lcrc_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            next_seq_q  <= next_seq_d;
            acked_seq_q <= acked_seq_d;
            tlp_q       <= tlp_d;
            lcrc_q      <= lcrc_d;
        end
    end

endmodule

// File: tb/tb_dll_tx_tlp_framer.sv
// Bench for dll_tx_tlp_framer: randomized traffic against a modulo-4096 sequence model
// and a table-driven CRC-32 reference (used when DLL_TX_LCRC_EN is defined).
module tb_dll_tx_tlp_framer;

    localparam int TW      = 256;
    localparam int MAX_OUT = 4;

    logic            clk;
    logic            rst_n;
    logic [1:0]      dlc_state_i;
    logic [TW-1:0]   tlp_i;
    logic            tlp_valid_i;
    logic            tlp_ready_o;
    logic [TW+43:0]  dll_tlp_o;
    logic            dll_tlp_valid_o;
    logic            dll_tlp_ready_i;
    logic            ack_valid_i;
    logic [11:0]     ack_seq_i;
    logic [11:0]     next_seq_o;
    logic [11:0]     acked_seq_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_next  = 0;
    int m_acked = 4095;

`ifdef DLL_TX_LCRC_EN
    logic [31:0] crc_tbl [256];
`endif

    dll_tx_tlp_framer #(
        .TLP_W           (TW),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dlc_state_i     (dlc_state_i),
        .tlp_i           (tlp_i),
        .tlp_valid_i     (tlp_valid_i),
        .tlp_ready_o     (tlp_ready_o),
        .dll_tlp_o       (dll_tlp_o),
        .dll_tlp_valid_o (dll_tlp_valid_o),
        .dll_tlp_ready_i (dll_tlp_ready_i),
        .ack_valid_i     (ack_valid_i),
        .ack_seq_i       (ack_seq_i),
        .next_seq_o      (next_seq_o),
        .acked_seq_o     (acked_seq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] rand_tlp();
        logic [TW-1:0] v;
        v = '0;
        for (int i = 0; i < TW / 32; i++) begin
            v = {v[TW-33:0], 32'($urandom())};
        end
        return v;
    endfunction

    function automatic int outstanding();
        return (m_next - m_acked - 1 + 8192) % 4096;
    endfunction

    function automatic void model_ack(input int seq);
        if (dlc_state_i != 2'b00 && ((m_next - 1 - seq + 8192) % 4096) < outstanding()) begin
            m_acked = seq;
        end
    endfunction

`ifdef DLL_TX_LCRC_EN
    function automatic void build_crc_tbl();
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = {n[7:0], 24'h0};
            for (int b = 0; b < 8; b++) begin
                c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
            end
            crc_tbl[n] = c;
        end
    endfunction

    // Byte-at-a-time CRC-32 over {4'b0, seq, tlp}
    function automatic logic [31:0] ref_crc(input int seq, input logic [TW-1:0] t);
        logic [TW+15:0] msg;
        logic [31:0]    c;
        logic [7:0]     b;
        msg = {4'b0000, 12'(seq), t};
        c   = 32'hFFFF_FFFF;
        for (int k = 0; k < (TW + 16) / 8; k++) begin
            b   = msg[TW+15 -: 8];
            msg = msg << 8;
            c   = (c << 8) ^ crc_tbl[c[31:24] ^ b];
        end
        return ~c;
    endfunction
`endif

    function automatic logic [TW+43:0] exp_frame(input int seq, input logic [TW-1:0] t);
        logic [31:0] l;
`ifdef DLL_TX_LCRC_EN
        l = ref_crc(seq, t);
`else
        l = 32'hDEAD_BEEF;
`endif
        return {12'(seq), t, l};
    endfunction

    task automatic do_reset();
        rst_n           = 1'b0;
        tlp_valid_i     = 1'b0;
        dll_tlp_ready_i = 1'b0;
        ack_valid_i     = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
        m_next  = 0;
        m_acked = 4095;
    endtask

    // Offer one TLP; model decides if it must be accepted. Optional Ack on the send edge.
    task automatic offer_tlp(input logic [TW-1:0] t, input int stall, input bit ack_en,
                             input int ack_seq, output bit sent);
        logic [TW+43:0] ef;
        bit             exp_rdy;
        sent    = 1'b0;
        exp_rdy = (dlc_state_i == 2'b11) && (outstanding() < MAX_OUT);
        n_vec++;
        if (tlp_ready_o !== exp_rdy) begin
            n_err++;
            $display("FAIL ready_idle got=%b want=%b", tlp_ready_o, exp_rdy);
        end
        tlp_i       = t;
        tlp_valid_i = 1'b1;
        if (!exp_rdy) begin
            for (int i = 0; i < 3; i++) begin
                step();
                n_vec++;
                if (dll_tlp_valid_o !== 1'b0 || tlp_ready_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL refused valid/ready got=%b%b want=00",
                             dll_tlp_valid_o, tlp_ready_o);
                end
            end
            tlp_valid_i = 1'b0;
            return;
        end
        step();
        tlp_valid_i = 1'b0;
        tlp_i       = rand_tlp();
        n_vec++;
        if (dll_tlp_valid_o !== 1'b0 || tlp_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL calc_cycle valid/ready got=%b%b want=00", dll_tlp_valid_o, tlp_ready_o);
        end
        step();
        ef = exp_frame(m_next, t);
        n_vec++;
        if (dll_tlp_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL latency valid got=%b want=1", dll_tlp_valid_o);
        end
        n_vec++;
        if (dll_tlp_o !== ef) begin
            n_err++;
            $display("FAIL frame got=%h want=%h", dll_tlp_o, ef);
        end
        for (int i = 0; i < stall; i++) begin
            step();
            n_vec++;
            if (dll_tlp_valid_o !== 1'b1 || dll_tlp_o !== ef || tlp_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold valid=%b ready=%b frame=%h want valid=1 ready=0 frame=%h",
                         dll_tlp_valid_o, tlp_ready_o, dll_tlp_o, ef);
            end
        end
        dll_tlp_ready_i = 1'b1;
        if (ack_en) begin
            ack_valid_i = 1'b1;
            ack_seq_i   = 12'(ack_seq);
            model_ack(ack_seq);
        end
        step();
        dll_tlp_ready_i = 1'b0;
        ack_valid_i     = 1'b0;
        m_next          = (m_next + 1) % 4096;
        n_vec++;
        if (dll_tlp_valid_o !== 1'b0 || next_seq_o !== 12'(m_next)
            || acked_seq_o !== 12'(m_acked)) begin
            n_err++;
            $display("FAIL post_send valid=%b next=%0d acked=%0d want valid=0 next=%0d acked=%0d",
                     dll_tlp_valid_o, next_seq_o, acked_seq_o, m_next, m_acked);
        end
        sent = 1'b1;
    endtask

    task automatic send_ack(input int seq);
        ack_valid_i = 1'b1;
        ack_seq_i   = 12'(seq);
        model_ack(seq);
        step();
        ack_valid_i = 1'b0;
        n_vec++;
        if (acked_seq_o !== 12'(m_acked)) begin
            n_err++;
            $display("FAIL ack seq=%0d acked got=%0d want=%0d", seq, acked_seq_o, m_acked);
        end
    endtask

    task automatic test_reset();
        dlc_state_i = 2'b11;
        tlp_i       = '0;
        ack_seq_i   = '0;
        do_reset();
        n_vec++;
        if (dll_tlp_valid_o !== 1'b0 || dll_tlp_o !== '0) begin
            n_err++;
            $display("FAIL reset_frame valid=%b frame=%h want 0", dll_tlp_valid_o, dll_tlp_o);
        end
        n_vec++;
        if (next_seq_o !== 12'd0 || acked_seq_o !== 12'd4095) begin
            n_err++;
            $display("FAIL reset_seq next=%0d acked=%0d want 0/4095", next_seq_o, acked_seq_o);
        end
        n_vec++;
        if (tlp_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got=%b want=1", tlp_ready_o);
        end
    endtask

    task automatic test_single();
        logic [TW-1:0] t;
        bit s;
        t = {(TW / 8){8'hA5}};
        offer_tlp(t, 0, 1'b0, 0, s);
        n_vec++;
        if (next_seq_o !== 12'd1) begin
            n_err++;
            $display("FAIL single_next got=%0d want=1", next_seq_o);
        end
    endtask

    task automatic test_stall();
        bit s;
        offer_tlp(rand_tlp(), 5, 1'b0, 0, s);
    endtask

    task automatic test_window();
        bit s;
        int cnt;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            offer_tlp(rand_tlp(), 0, 1'b0, 0, s);
            cnt += int'(s);
        end
        n_vec++;
        if (cnt != 4 || tlp_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL window_fill sent=%0d ready=%b want sent=4 ready=0", cnt, tlp_ready_o);
        end
        send_ack(1);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            offer_tlp(rand_tlp(), 0, 1'b0, 0, s);
            cnt += int'(s);
        end
        n_vec++;
        if (cnt != 2 || acked_seq_o !== 12'd1) begin
            n_err++;
            $display("FAIL window_after_ack sent=%0d acked=%0d want sent=2 acked=1",
                     cnt, acked_seq_o);
        end
    endtask

    task automatic test_random_traffic();
        bit s;
        int a;
        do_reset();
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 1) == 1 && outstanding() > 0) begin
                a = (m_acked + 1 + int'($urandom_range(0, 32'(outstanding() - 1)))) % 4096;
            end else begin
                a = int'($urandom_range(0, 4095));
            end
            case ($urandom_range(0, 3))
                0, 1: offer_tlp(rand_tlp(), int'($urandom_range(0, 3)),
                                1'($urandom_range(0, 1)), a, s);
                2: send_ack(a);
                default: begin
                    step();
                    n_vec++;
                    if (tlp_ready_o !== (outstanding() < MAX_OUT)) begin
                        n_err++;
                        $display("FAIL idle_ready got=%b want=%b", tlp_ready_o,
                                 outstanding() < MAX_OUT);
                    end
                end
            endcase
        end
    endtask

    task automatic test_dl_down();
        bit s;
        do_reset();
        offer_tlp(rand_tlp(), 0, 1'b0, 0, s);
        // Abort while in SEND with downstream ready
        tlp_i       = rand_tlp();
        tlp_valid_i = 1'b1;
        step();
        tlp_valid_i = 1'b0;
        step();
        n_vec++;
        if (dll_tlp_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL dl_down_presend valid got=%b want=1", dll_tlp_valid_o);
        end
        dlc_state_i     = 2'b01;
        dll_tlp_ready_i = 1'b1;
        step();
        dll_tlp_ready_i = 1'b0;
        n_vec++;
        if (dll_tlp_valid_o !== 1'b0 || next_seq_o !== 12'(m_next) || tlp_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL dl_down_send valid=%b next=%0d ready=%b want 0/%0d/0",
                     dll_tlp_valid_o, next_seq_o, tlp_ready_o, m_next);
        end
        // Abort while in CALC
        dlc_state_i = 2'b11;
        step();
        tlp_valid_i = 1'b1;
        step();
        tlp_valid_i = 1'b0;
        dlc_state_i = 2'b10;
        step();
        step();
        n_vec++;
        if (dll_tlp_valid_o !== 1'b0 || next_seq_o !== 12'(m_next)) begin
            n_err++;
            $display("FAIL dl_down_calc valid=%b next=%0d want 0/%0d",
                     dll_tlp_valid_o, next_seq_o, m_next);
        end
        // DL_INACTIVE forces the counters and blocks Acks
        dlc_state_i = 2'b00;
        step();
        m_next  = 0;
        m_acked = 4095;
        n_vec++;
        if (next_seq_o !== 12'd0 || acked_seq_o !== 12'd4095) begin
            n_err++;
            $display("FAIL dl_inactive next=%0d acked=%0d want 0/4095", next_seq_o, acked_seq_o);
        end
        send_ack(0);
        dlc_state_i = 2'b11;
        step();
        offer_tlp(rand_tlp(), 1, 1'b0, 0, s);
    endtask

    task automatic test_reset_mid_send();
        bit s;
        do_reset();
        offer_tlp(rand_tlp(), 0, 1'b0, 0, s);
        tlp_i       = rand_tlp();
        tlp_valid_i = 1'b1;
        step();
        tlp_valid_i = 1'b0;
        step();
        rst_n           = 1'b0;
        dll_tlp_ready_i = 1'b1;
        step();
        rst_n           = 1'b1;
        dll_tlp_ready_i = 1'b0;
        m_next  = 0;
        m_acked = 4095;
        n_vec++;
        if (dll_tlp_valid_o !== 1'b0 || dll_tlp_o !== '0 || next_seq_o !== 12'd0
            || acked_seq_o !== 12'd4095) begin
            n_err++;
            $display("FAIL reset_mid_send valid=%b next=%0d acked=%0d frame=%h want all reset",
                     dll_tlp_valid_o, next_seq_o, acked_seq_o, dll_tlp_o);
        end
    endtask

    task automatic test_wrap();
        bit s;
        do_reset();
        while (m_next != 4095) begin
            offer_tlp(rand_tlp(), 0, 1'b0, 0, s);
            send_ack((m_next + 4095) % 4096);
        end
        offer_tlp(rand_tlp(), 0, 1'b0, 0, s);
        n_vec++;
        if (next_seq_o !== 12'd0) begin
            n_err++;
            $display("FAIL wrap_next got=%0d want=0", next_seq_o);
        end
        send_ack(4000);
        n_vec++;
        if (acked_seq_o !== 12'd4094) begin
            n_err++;
            $display("FAIL wrap_stale_ack acked got=%0d want=4094", acked_seq_o);
        end
    endtask

    task automatic test_lcrc();
        bit s;
        for (int i = 0; i < 100; i++) begin
            do_reset();
            offer_tlp(rand_tlp(), 0, 1'b0, 0, s);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        dlc_state_i     = 2'b11;
        tlp_i           = '0;
        tlp_valid_i     = 1'b0;
        dll_tlp_ready_i = 1'b0;
        ack_valid_i     = 1'b0;
        ack_seq_i       = '0;
`ifdef DLL_TX_LCRC_EN
        build_crc_tbl();
`endif
        test_reset();
        test_single();
        test_stall();
        test_window();
        test_random_traffic();
        test_dl_down();
        test_reset_mid_send();
        test_wrap();
        test_lcrc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
